// File: rtl/irq_nest_ctrl.sv
// Nested-interrupt context controller: priority-arbitrates interrupt lines,
// stacks the interrupted PC and priority, and redirects the PC on ISR entry
// and on eret resume. Redirect decisions are combinational for same-cycle PC
// selection. Registered state holds the nesting depth, current priority and
// the sticky error flags.
module irq_nest_ctrl #(
  parameter  int N_IRQ = 4,
  parameter  int DEPTH = 4,
  parameter  int AW    = 32,
  localparam int PW    = $clog2(N_IRQ + 1),
  localparam int DW    = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [N_IRQ-1:0]    irq_req,
  input  logic [N_IRQ-1:0]    irq_mask,
  input  logic [N_IRQ*AW-1:0] irq_vec,
  input  logic                eret,
  input  logic [AW-1:0]       pc_next_mips,
  output logic                redirect,
  output logic [AW-1:0]       pc_target,
  output logic [N_IRQ-1:0]    irq_ack,
  output logic                irq_active,
  output logic [PW-1:0]       cur_prio,
  output logic [DW-1:0]       depth,
  output logic                err_sat,
  output logic                err_unf
);

  // Index widths for the interrupt lines and for the stack slots.
  localparam int IW = (N_IRQ > 1) ? $clog2(N_IRQ) : 1;
  localparam int SW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [DW-1:0] DEPTH_MAX = DW'(DEPTH);
  localparam logic [PW-1:0] PRIO_IDLE = PW'(N_IRQ);

  typedef struct packed {
    logic [AW-1:0] pc;
    logic [PW-1:0] prio;
  } ctx_t;

  ctx_t             stack [DEPTH];
  ctx_t             top;
  logic [N_IRQ-1:0] elig;
  logic             found;
  logic [IW-1:0]    w_idx;
  logic [PW-1:0]    w_prio;
  logic [AW-1:0]    w_vec;
  logic [SW-1:0]    push_idx;
  logic [SW-1:0]    top_idx;
  logic             live;
  logic             preempt;
  logic             entry;
  logic             resume;
  logic             sat;
  logic             unf;

  assign elig     = irq_req & irq_mask;
  assign w_prio   = PW'(w_idx);
  assign push_idx = SW'(depth);
  assign top_idx  = SW'(depth - 1'b1);
  assign top      = stack[top_idx];

  // Priority encoder: the lowest-index eligible line wins. The loop runs from
  // the highest index down so that the last match is the winning line.
  // NOTE: every variable written here gets a default first, so no latch is inferred.
  always_comb begin
    found = 1'b0;
    w_idx = '0;
    w_vec = '0;
    for (int i = N_IRQ - 1; i >= 0; i--) begin
      if (elig[i]) begin
        found = 1'b1;
        w_idx = IW'(i);
        w_vec = irq_vec[i*AW +: AW];
      end
    end
  end

  // Event decode. Resume takes precedence over entry, and reset or en=0
  // suppresses every event.
  assign live    = rst & en;
  assign preempt = live & ~eret & found & (w_prio < cur_prio);
  assign entry   = preempt & (depth < DEPTH_MAX);
  assign sat     = preempt & (depth == DEPTH_MAX);
  assign resume  = live & eret & (depth != '0);
  assign unf     = live & eret & (depth == '0);

  // Same-cycle PC redirect and one-hot acknowledge.
  always_comb begin
    redirect  = entry | resume;
    pc_target = pc_next_mips;
    irq_ack   = '0;
    if (entry) begin
      pc_target      = w_vec;
      irq_ack[w_idx] = 1'b1;
    end else if (resume) begin
      pc_target = top.pc;
    end
  end

  // Depth, current priority and sticky error flags, with synchronous reset.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (!rst) begin
      depth    <= '0;
      cur_prio <= PRIO_IDLE;
      err_sat  <= 1'b0;
      err_unf  <= 1'b0;
    end else begin
      if (entry) begin
        depth    <= depth + 1'b1;
        cur_prio <= w_prio;
      end else if (resume) begin
        depth    <= depth - 1'b1;
        cur_prio <= top.prio;
      end
      if (sat) err_sat <= 1'b1;
      if (unf) err_unf <= 1'b1;
    end
  end

  // Context push on entry. A pop only moves depth, so no write is needed.
  // NOTE: the stack has no reset. A slot is always written before depth makes it readable.
  always_ff @(posedge clk) begin
    if (entry) stack[push_idx] <= '{pc: pc_next_mips, prio: cur_prio};
  end

  assign irq_active = (depth != '0);

endmodule

// File: tb/tb_irq_nest_ctrl.sv
// Directed bench for irq_nest_ctrl (N_IRQ=4, DEPTH=2, AW=32). Inputs are driven
// on the falling edge. Combinational outputs are checked 1 time unit later, and
// registered outputs are checked at the following falling edge.
module tb_irq_nest_ctrl;

  localparam int N_IRQ = 4;
  localparam int DEPTH = 2;
  localparam int AW    = 32;

  logic                clk = 1'b0;
  logic                rst;
  logic                en;
  logic [N_IRQ-1:0]    irq_req;
  logic [N_IRQ-1:0]    irq_mask;
  logic [N_IRQ*AW-1:0] irq_vec;
  logic                eret;
  logic [AW-1:0]       pc_next_mips;
  logic                redirect;
  logic [AW-1:0]       pc_target;
  logic [N_IRQ-1:0]    irq_ack;
  logic                irq_active;
  logic [2:0]          cur_prio;
  logic [1:0]          depth;
  logic                err_sat;
  logic                err_unf;

  int passed = 0;
  int total  = 0;

  irq_nest_ctrl #(.N_IRQ(N_IRQ), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk(clk), .rst(rst), .en(en), .irq_req(irq_req), .irq_mask(irq_mask),
    .irq_vec(irq_vec), .eret(eret), .pc_next_mips(pc_next_mips),
    .redirect(redirect), .pc_target(pc_target), .irq_ack(irq_ack),
    .irq_active(irq_active), .cur_prio(cur_prio), .depth(depth),
    .err_sat(err_sat), .err_unf(err_unf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic check_comb(input string tag, input logic r, input logic [31:0] t,
                            input logic [3:0] a);
    check({tag, ".redirect"}, 32'(redirect), 32'(r));
    check({tag, ".pc_target"}, pc_target, t);
    check({tag, ".irq_ack"}, 32'(irq_ack), 32'(a));
  endtask

  task automatic check_regs(input string tag, input logic [1:0] d, input logic [2:0] p,
                            input logic act, input logic s, input logic u);
    check({tag, ".depth"}, 32'(depth), 32'(d));
    check({tag, ".cur_prio"}, 32'(cur_prio), 32'(p));
    check({tag, ".irq_active"}, 32'(irq_active), 32'(act));
    check({tag, ".err_sat"}, 32'(err_sat), 32'(s));
    check({tag, ".err_unf"}, 32'(err_unf), 32'(u));
  endtask

  initial begin
    irq_vec      = {32'h500, 32'h400, 32'h300, 32'h200};
    rst          = 1'b0;
    en           = 1'b1;
    irq_mask     = 4'hF;
    irq_req      = 4'b0000;
    eret         = 1'b0;
    pc_next_mips = 32'h100;

    // Reset: outputs are forced even when a request is eligible.
    @(negedge clk);
    @(negedge clk);
    irq_req = 4'b0100;
    #1 check_comb("rst_forced", 1'b0, 32'h100, 4'b0000);
    @(negedge clk);
    check_regs("rst_state", 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    irq_req = 4'b0000;

    // Enter line 2.
    @(negedge clk);
    irq_req = 4'b0100;
    #1 check_comb("entry_l2", 1'b1, 32'h400, 4'b0100);
    @(negedge clk);
    check_regs("after_l2", 2'd1, 3'd2, 1'b1, 1'b0, 1'b0);

    // Equal priority is held.
    #1 check_comb("equal_prio", 1'b0, 32'h100, 4'b0000);

    // A masked line 0 request is ignored.
    @(negedge clk);
    irq_mask = 4'b1110;
    irq_req  = 4'b0001;
    #1 check_comb("masked_l0", 1'b0, 32'h100, 4'b0000);

    // Line 1 preempts line 2 and fills the stack.
    @(negedge clk);
    check_regs("masked_hold", 2'd1, 3'd2, 1'b1, 1'b0, 1'b0);
    irq_mask     = 4'hF;
    irq_req      = 4'b0110;
    pc_next_mips = 32'h410;
    #1 check_comb("entry_l1", 1'b1, 32'h300, 4'b0010);
    @(negedge clk);
    check_regs("after_l1", 2'd2, 3'd1, 1'b1, 1'b0, 1'b0);

    // Equal and lower priority requests at full depth do not preempt and do not saturate.
    irq_req      = 4'b1010;
    pc_next_mips = 32'h304;
    #1 check_comb("eq_low_full", 1'b0, 32'h304, 4'b0000);
    @(negedge clk);
    check_regs("no_sat", 2'd2, 3'd1, 1'b1, 1'b0, 1'b0);

    // Line 0 at full depth is blocked and sets err_sat.
    irq_req = 4'b0001;
    #1 check_comb("sat_block", 1'b0, 32'h304, 4'b0000);
    @(negedge clk);
    check_regs("sat_flag", 2'd2, 3'd1, 1'b1, 1'b1, 1'b0);

    // Resume the line-2 ISR. Line 0 is still pending.
    eret = 1'b1;
    #1 check_comb("eret_1", 1'b1, 32'h410, 4'b0000);
    @(negedge clk);
    check_regs("after_eret1", 2'd1, 3'd2, 1'b1, 1'b1, 1'b0);

    // Resume and a line 0 request in the same cycle: resume wins.
    pc_next_mips = 32'h414;
    #1 check_comb("eret_vs_l0", 1'b1, 32'h100, 4'b0000);
    @(negedge clk);
    check_regs("after_eret2", 2'd0, 3'd4, 1'b0, 1'b1, 1'b0);

    // Line 0 is taken on the next cycle. The resumed program's next PC is saved.
    eret         = 1'b0;
    pc_next_mips = 32'h104;
    #1 check_comb("entry_l0", 1'b1, 32'h200, 4'b0001);
    @(negedge clk);
    check_regs("after_l0", 2'd1, 3'd0, 1'b1, 1'b1, 1'b0);
    irq_req      = 4'b0000;
    eret         = 1'b1;
    pc_next_mips = 32'h204;
    #1 check_comb("eret_l0", 1'b1, 32'h104, 4'b0000);
    @(negedge clk);
    check_regs("after_eret_l0", 2'd0, 3'd4, 1'b0, 1'b1, 1'b0);

    // An eret at depth 0 underflows.
    pc_next_mips = 32'h108;
    #1 check_comb("unf", 1'b0, 32'h108, 4'b0000);
    @(negedge clk);
    check_regs("unf_flag", 2'd0, 3'd4, 1'b0, 1'b1, 1'b1);

    // With en=0, nothing is redirected and all state holds.
    eret    = 1'b0;
    en      = 1'b0;
    irq_req = 4'b0100;
    #1 check_comb("en_off", 1'b0, 32'h108, 4'b0000);
    @(negedge clk);
    check_regs("en_hold", 2'd0, 3'd4, 1'b0, 1'b1, 1'b1);

    // Nest to depth 2, then reset mid-ISR.
    en = 1'b1;
    #1 check_comb("re_entry_l2", 1'b1, 32'h400, 4'b0100);
    @(negedge clk);
    irq_req = 4'b0010;
    @(negedge clk);
    check_regs("depth2", 2'd2, 3'd1, 1'b1, 1'b1, 1'b1);
    rst     = 1'b0;
    irq_req = 4'b0001;
    #1 check_comb("rst_mid", 1'b0, 32'h108, 4'b0000);
    @(negedge clk);
    check_regs("rst_mid_state", 2'd0, 3'd4, 1'b0, 1'b0, 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/irq_nest_ctrl.md
# irq_nest_ctrl

Parametrised nested-interrupt context controller for the MIPS core. It replaces the single saved-PC / single `irq_active` scheme with a priority-arbitrated, multi-level PC context stack. It sits beside the datapath PC-selection chain: it consumes the program's next PC and the decoded resume (eret) strobe, and supplies the PC redirect and target for that same cycle.

## Interface
- `N_IRQ`, 4: number of interrupt lines; index 0 is highest priority.
- `DEPTH`, 4: maximum nesting depth, i.e. number of stacked contexts (≥1).
- `AW`, 32: PC / vector address width.
- `PW` (localparam), `$clog2(N_IRQ+1)`: priority-code width. Value `N_IRQ` means "program level".
- `DW` (localparam), `$clog2(DEPTH+1)`: depth-counter width.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst`  in  1  synchronous, active-low reset (asserted when 0).
- `en`  in  1  core advance enable; when 0, no state change and no redirect.
- `irq_req`  in  N_IRQ  level-sensitive pending requests.
- `irq_mask`  in  N_IRQ  1 = line enabled.
- `irq_vec`  in  N_IRQ*AW  flattened ISR addresses; line i occupies bits `[i*AW +: AW]`.
- `eret`  in  1  resume instruction decoded this cycle.
- `pc_next_mips`  in  AW  PC the program would take this cycle (branch/jump/jr already resolved).
- `redirect`  out  1  combinational; 1 = the datapath must load `pc_target` instead of `pc_next_mips`.
- `pc_target`  out  AW  combinational; ISR vector on entry, popped PC on resume, else `pc_next_mips`.
- `irq_ack`  out  N_IRQ  combinational one-hot pulse identifying the line entered this cycle.
- `irq_active`  out  1  registered; 1 when depth > 0.
- `cur_prio`  out  PW  registered; priority of the running context.
- `depth`  out  DW  registered; number of stacked contexts.
- `err_sat`  out  1  sticky; an eligible preemption was blocked because the stack was full.
- `err_unf`  out  1  sticky; `eret` arrived with depth 0.

## Operation
- Eligible set: `irq_req & irq_mask`. The winner `w` is the lowest set index.
- **Entry** fires when all of the following hold: `en=1`, `eret=0`, the eligible set is non-empty, `w < cur_prio`, and `depth < DEPTH`. On entry:
  - `redirect=1`, `pc_target=irq_vec[w]`, `irq_ack[w]=1`.
  - At the clock edge, push `{pc_next_mips, cur_prio}`, then set `cur_prio←w` and `depth←depth+1`.
- **Resume** fires when `en=1`, `eret=1`, and `depth>0`. On resume:
  - `redirect=1`, `pc_target` = top-of-stack PC.
  - At the clock edge, pop, then set `cur_prio←` the stacked prio and `depth←depth-1`.
- **Simultaneous eret and eligible request:** resume wins. Entry is re-evaluated next cycle against the restored `cur_prio`; there is no same-cycle tail-chain.
- **`eret` with depth 0:** no redirect, no state change, `err_unf←1`.
- **Eligible `w < cur_prio` with depth == DEPTH:** no entry, `err_sat←1`. The request stays pending and fires once depth drops.
- **Requests with `w ≥ cur_prio`:** held, never acked. Equal priority does not preempt.
- **`en=0`:** `redirect=0`, `irq_ack=0`, `pc_target=pc_next_mips`, and all registers hold.
- Stack is a DEPTH-entry array of width AW+PW indexed by `depth`. No wrap-around: push at full and pop at empty are both prevented by the rules above.
- Error flags clear only on reset.

## Timing
- Decision latency is 0 cycles: `redirect`, `pc_target` and `irq_ack` are combinational from the current inputs and registered state, so they are valid in the same cycle the PC register samples.
- Registered outputs change one edge after entry or resume.
- A new ISR can itself be preempted from the cycle after entry by any `w` below the new `cur_prio`.
- **Reset (`rst=0` at an edge):**
  - Values taking effect at that edge: `depth=0`, `cur_prio=N_IRQ`, `irq_active=0`, `err_sat=0`, `err_unf=0`; stack contents are don't-care.
  - Forced while `rst=0`: `redirect=0`, `irq_ack=0`, `pc_target=pc_next_mips`.
  - Reset mid-ISR abandons all stacked contexts.

## Test plan
- **Basic entry/resume (N_IRQ=4, DEPTH=2, AW=32).** irq_mask=4'hF, irq_vec[2]=0x400, pc_next_mips=0x100, pulse irq_req=4'b0100 → same cycle redirect=1, pc_target=0x400, irq_ack=4'b0100; next cycle cur_prio=2, depth=1. Later eret=1 → pc_target=0x100; next cycle cur_prio=4, depth=0, irq_active=0.
- **Nesting and saturation.** In line-2 ISR, raise line 1 (vec 0x300, pc_next 0x410) → entry, depth=2. Raise line 0 → no redirect, err_sat=1. Two erets → targets 0x410 then 0x100; line 0 is then taken at depth 0 if still requested.
- **No equal or lower preemption.** In line-1 ISR, assert lines 1 and 3 → redirect=0, irq_ack=0. Masked line 0 with irq_mask=4'b1110 → ignored.
- **Simultaneous events.** depth=1, cur_prio=2, eret=1 together with irq_req[0]=1 → resume this cycle; entry to line 0 occurs the following cycle with its saved PC equal to the resumed program's next PC.
- **Underflow, enable and reset.** eret at depth 0 → redirect=0, err_unf=1. en=0 with an eligible request → no redirect and state holds. rst=0 at depth 2 → depth=0, cur_prio=4, both error flags 0 after the edge.
